// File: rtl/bc_pkg.sv
// Shared constants for the BC_I control path.
// Word layout, counter sizing and opcode indices.
package bc_pkg;

  localparam int WORD       = 16;
  localparam int SC_WIDTH   = 4;
  localparam int T_WIDTH    = 2**SC_WIDTH;
  localparam int INPR_WIDTH = 8;
  localparam int D_WIDTH    = 8;

  localparam int IND_BIT    = WORD-1;
  localparam int OPCODE_MSB = WORD-2;
  localparam int OPCODE_LSB = WORD-4;

  localparam int OP_AND = 0;
  localparam int OP_ADD = 1;
  localparam int OP_LDA = 2;
  localparam int OP_STA = 3;
  localparam int OP_BUN = 4;
  localparam int OP_BSA = 5;
  localparam int OP_ISZ = 6;
  localparam int OP_IO  = 7;

  function automatic logic [D_WIDTH-1:0] op_decode(
    input logic [OPCODE_MSB-OPCODE_LSB:0] op
  );
    return D_WIDTH'(1) << op;
  endfunction

endpackage

// File: rtl/timing_control_unit_if.sv
// Strobe/flag bundle between control logic and timing unit.
// master = control logic side, slave = timing unit.
interface timing_control_unit_if;
  import bc_pkg::*;

  logic [WORD-1:0]       IR;
  logic                  incrSC;
  logic                  clrSC;
  logic                  write_enable_I;
  logic                  setR;
  logic                  resetR;
  logic                  setIEN;
  logic                  resetIEN;
  logic                  setS;
  logic                  resetS;
  logic                  start;
  logic                  clrFGI;
  logic                  in_strobe;
  logic [INPR_WIDTH-1:0] in_data;

  logic                  in_ready;
  logic [INPR_WIDTH-1:0] INPR;
  logic                  FGI;
  logic [T_WIDTH-1:0]    T;
  logic [D_WIDTH-1:0]    D;
  logic                  I;
  logic                  R;
  logic                  IEN;
  logic                  S;
  logic [SC_WIDTH-1:0]   SC;

  modport master (
    output IR, incrSC, clrSC, write_enable_I,
    output setR, resetR, setIEN, resetIEN,
    output setS, resetS, start,
    output clrFGI, in_strobe, in_data,
    input  in_ready, INPR, FGI, T, D,
    input  I, R, IEN, S, SC
  );

  modport slave (
    input  IR, incrSC, clrSC, write_enable_I,
    input  setR, resetR, setIEN, resetIEN,
    input  setS, resetS, start,
    input  clrFGI, in_strobe, in_data,
    output in_ready, INPR, FGI, T, D,
    output I, R, IEN, S, SC
  );

endinterface

// File: rtl/seq_counter.sv
// Sequence counter SC with one-hot timing decode T.
// T is forced to zero while halted so no control term fires.
module seq_counter
  import bc_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic                halt_i,
  input  logic                clr_i,
  input  logic                incr_i,
  output logic [SC_WIDTH-1:0] sc_o,
  output logic [T_WIDTH-1:0]  t_o
);

  logic [SC_WIDTH-1:0] sc_q;
  logic [SC_WIDTH-1:0] sc_d;

  // start overrides the halt freeze so a restart always lands on T0
  always_comb begin
    sc_d = sc_q;
    if (start_i)
      sc_d = '0;
    else if (halt_i)
      sc_d = sc_q;
    else if (clr_i)
      sc_d = '0;
    else if (incr_i)
      sc_d = sc_q + SC_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sc_q <= '0;
    else
      sc_q <= sc_d;
  end

  assign sc_o = sc_q;
  assign t_o  = halt_i ? '0 : (T_WIDTH'(1) << sc_q);

endmodule

// File: rtl/timing_control_unit.sv
// Sequential front end of the BC_I control path:
// SC/T, opcode decode D, flag flops I/R/IEN/S and the FGI/INPR port.
module timing_control_unit
  import bc_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  timing_control_unit_if.slave bus
);

  logic                  i_q,    i_d;
  logic                  r_q,    r_d;
  logic                  ien_q,  ien_d;
  logic                  s_q,    s_d;
  logic                  fgi_q,  fgi_d;
  logic [INPR_WIDTH-1:0] inpr_q, inpr_d;

  seq_counter u_seq (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (bus.start),
    .halt_i  (s_q),
    .clr_i   (bus.clrSC),
    .incr_i  (bus.incrSC),
    .sc_o    (bus.SC),
    .t_o     (bus.T)
  );

  always_comb begin
    i_d   = i_q;
    r_d   = r_q;
    ien_d = ien_q;
    s_d   = s_q;
    if (!s_q) begin
      if (bus.write_enable_I)
        i_d = bus.IR[IND_BIT];
      if (bus.resetR)
        r_d = 1'b0;
      else if (bus.setR)
        r_d = 1'b1;
      if (bus.resetIEN)
        ien_d = 1'b0;
      else if (bus.setIEN)
        ien_d = 1'b1;
    end
    if (bus.start || bus.resetS)
      s_d = 1'b0;
    else if (bus.setS)
      s_d = 1'b1;
  end

  // input port runs regardless of S; a strobe only lands while FGI=0
  always_comb begin
    fgi_d  = fgi_q;
    inpr_d = inpr_q;
    if (bus.in_strobe && !fgi_q) begin
      fgi_d  = 1'b1;
      inpr_d = bus.in_data;
    end else if (bus.clrFGI) begin
      fgi_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_q    <= 1'b0;
      r_q    <= 1'b0;
      ien_q  <= 1'b0;
      s_q    <= 1'b0;
      fgi_q  <= 1'b0;
      inpr_q <= '0;
    end else begin
      i_q    <= i_d;
      r_q    <= r_d;
      ien_q  <= ien_d;
      s_q    <= s_d;
      fgi_q  <= fgi_d;
      inpr_q <= inpr_d;
    end
  end

  assign bus.D        = op_decode(bus.IR[OPCODE_MSB:OPCODE_LSB]);
  assign bus.I        = i_q;
  assign bus.R        = r_q;
  assign bus.IEN      = ien_q;
  assign bus.S        = s_q;
  assign bus.FGI      = fgi_q;
  assign bus.INPR     = inpr_q;
  assign bus.in_ready = ~fgi_q;

endmodule
